// File: rtl/quantize_drain_pkg.sv
// Shared types and constants for the quantize/drain stage feeding SRAM write-out.
// Optional round-half-up quantization is enabled with the QUANT_ROUND_EN macro.
package quantize_drain_pkg;

  localparam int ARRAY_SIZE        = 8;
  localparam int ACC_WIDTH         = 32;
  localparam int OUTPUT_DATA_WIDTH = 16;

  localparam int LAST_BEAT = 2*ARRAY_SIZE-2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_t;

  // Saturation bounds expressed in the widened ACC_WIDTH+1 shift domain
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    $signed({{(ACC_WIDTH-OUTPUT_DATA_WIDTH+2){1'b0}}, {(OUTPUT_DATA_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    $signed({{(ACC_WIDTH-OUTPUT_DATA_WIDTH+2){1'b1}}, {(OUTPUT_DATA_WIDTH-1){1'b0}}});

endpackage

// File: rtl/quantize_drain_quant_lane.sv
// One lane of the quantizer: arithmetic right shift then saturate to the output width.
// With QUANT_ROUND_EN defined, a half-LSB bias is added before the shift (round-half-up).
module quant_lane
  import quantize_drain_pkg::*;
(
  input  logic [ACC_WIDTH-1:0]         acc_in,
  input  logic [4:0]                   shift,
  output logic [OUTPUT_DATA_WIDTH-1:0] quant_out
);

  logic signed [ACC_WIDTH:0] extended;
  logic signed [ACC_WIDTH:0] shifted;

  // One extra bit of headroom keeps the rounding bias from overflowing
  always_comb begin
    extended = $signed({acc_in[ACC_WIDTH-1], acc_in});
`ifdef QUANT_ROUND_EN
    if (shift != 5'd0) begin
      extended = extended + $signed((ACC_WIDTH+1)'(1) << (shift - 5'd1));
    end
`endif
    shifted = extended >>> shift;
    if (shifted > SAT_MAX) begin
      quant_out = SAT_MAX[OUTPUT_DATA_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      quant_out = SAT_MIN[OUTPUT_DATA_WIDTH-1:0];
    end else begin
      quant_out = shifted[OUTPUT_DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/quantize_drain.sv
// Drains one skewed result matrix (2*ARRAY_SIZE-1 diagonal beats), quantizing every lane.
// Rounding mode of the lanes is selected by the QUANT_ROUND_EN macro.
module quantize_drain
  import quantize_drain_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    srstn,
  input  logic                                    start,
  input  logic                                    acc_valid,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]         acc_data,
  input  logic [4:0]                              shift,
  output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] quantized_data,
  output logic                                    sram_write_enable,
  output logic [5:0]                              matrix_index,
  output logic [9:0]                              data_set,
  output logic                                    busy,
  output logic                                    done
);

  drain_state_t state, next_state;

  logic [4:0] shift_q, shift_next;
  logic [5:0] beat_cnt, beat_next;

  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] quant_comb, quant_next;
  logic       swe_next;
  logic [5:0] index_next;
  logic [9:0] data_set_next;
  logic       busy_next;
  logic       done_next;

  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    quant_lane u_quant_lane (
      .acc_in    (acc_data[g*ACC_WIDTH +: ACC_WIDTH]),
      .shift     (shift_q),
      .quant_out (quant_comb[g*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH])
    );
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = DRAIN;
      DRAIN:   if (acc_valid && (beat_cnt == 6'(LAST_BEAT))) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Data and index hold between beats; only the write strobe drops on a stall
  always_comb begin
    shift_next    = shift_q;
    beat_next     = beat_cnt;
    quant_next    = quantized_data;
    index_next    = matrix_index;
    data_set_next = data_set;
    swe_next      = 1'b0;
    done_next     = 1'b0;
    busy_next     = (next_state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          shift_next = shift;
          beat_next  = 6'd0;
        end
      end
      DRAIN: begin
        if (acc_valid) begin
          quant_next = quant_comb;
          swe_next   = 1'b1;
          index_next = beat_cnt;
          beat_next  = beat_cnt + 6'd1;
        end
      end
      DONE: begin
        swe_next      = acc_valid;
        done_next     = 1'b1;
        data_set_next = data_set + 10'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      shift_q           <= '0;
      beat_cnt          <= '0;
      quantized_data    <= '0;
      sram_write_enable <= 1'b0;
      matrix_index      <= '0;
      data_set          <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      shift_q           <= shift_next;
      beat_cnt          <= beat_next;
      quantized_data    <= quant_next;
      sram_write_enable <= swe_next;
      matrix_index      <= index_next;
      data_set          <= data_set_next;
      busy              <= busy_next;
      done              <= done_next;
    end
  end

endmodule

// File: tb/tb_quantize_drain.sv
// Directed-plus-random bench for quantize_drain against an arithmetic quantization model.
// Expected rounding follows QUANT_ROUND_EN, the same macro that configures the design.
module tb_quantize_drain;
  import quantize_drain_pkg::*;

  logic         clk;
  logic         srstn;
  logic         start;
  logic         acc_valid;
  logic [255:0] acc_data;
  logic [4:0]   shift;
  logic [127:0] quantized_data;
  logic         sram_write_enable;
  logic [5:0]   matrix_index;
  logic [9:0]   data_set;
  logic         busy;
  logic         done;

  int vectors = 0;
  int miscompares = 0;
  int exp_ds = 0;
  logic [127:0] saved_beat0;

  quantize_drain dut (
    .clk               (clk),
    .srstn             (srstn),
    .start             (start),
    .acc_valid         (acc_valid),
    .acc_data          (acc_data),
    .shift             (shift),
    .quantized_data    (quantized_data),
    .sram_write_enable (sram_write_enable),
    .matrix_index      (matrix_index),
    .data_set          (data_set),
    .busy              (busy),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Floor (or round-half-up) division by 2^s, then clamp to int16
  function automatic logic [15:0] ref_quant(input logic signed [31:0] x, input int s);
    longint v, d, q;
    v = longint'(x);
    d = longint'(1) << s;
`ifdef QUANT_ROUND_EN
    if (s > 0) v = v + d / 2;
`endif
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  function automatic logic [127:0] ref_beat(input logic [255:0] d, input int s);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = ref_quant(d[i*32 +: 32], s);
    return r;
  endfunction

  function automatic logic [255:0] pattern_data(input int b);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'(b*8 + i);
    return d;
  endfunction

  function automatic logic [255:0] random_data();
    logic [255:0] d;
    logic signed [31:0] lane;
    for (int i = 0; i < 8; i++) begin
      lane = $signed($urandom);
      if ($urandom_range(0, 1) == 1) lane = lane >>> $urandom_range(8, 24);
      d[i*32 +: 32] = lane;
    end
    return d;
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled at the same point
  task automatic apply_stimulus(input logic st, input logic v, input logic [255:0] d, input logic [4:0] sh);
    start     = st;
    acc_valid = v;
    acc_data  = d;
    shift     = sh;
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = lane i of beat b is b*8+i, 1 = random, 2 = random with beat 0 forced
  task automatic run_drain(input int kind, input logic [4:0] sh, input int stall_after,
                           input bit noise, input logic [255:0] beat0);
    logic [127:0] exp_q;
    logic [255:0] d;
    logic v;
    apply_stimulus(1'b1, noise ? 1'($urandom) : 1'b0, random_data(), sh);
    check_output("start_swe", 128'(sram_write_enable), 128'(0));
    check_output("start_busy", 128'(busy), 128'(1));
    check_output("start_done", 128'(done), 128'(0));
    exp_q = quantized_data;
    for (int b = 0; b <= 14; b++) begin
      d = (kind == 0) ? pattern_data(b) : random_data();
      if (kind == 2 && b == 0) d = beat0;
      apply_stimulus(noise ? 1'($urandom) : 1'b0, 1'b1, d, noise ? 5'($urandom) : sh);
      exp_q = ref_beat(d, int'(sh));
      if (b == 0) saved_beat0 = quantized_data;
      check_output("beat_swe", 128'(sram_write_enable), 128'(1));
      check_output("beat_index", 128'(matrix_index), 128'(b));
      check_output("beat_data", quantized_data, exp_q);
      check_output("beat_busy", 128'(busy), 128'(1));
      check_output("beat_done", 128'(done), 128'(0));
      if (b == stall_after) begin
        for (int k = 0; k < 3; k++) begin
          apply_stimulus(noise ? 1'($urandom) : 1'b0, 1'b0, random_data(), 5'($urandom));
          check_output("stall_swe", 128'(sram_write_enable), 128'(0));
          check_output("stall_index", 128'(matrix_index), 128'(b));
          check_output("stall_data", quantized_data, exp_q);
          check_output("stall_busy", 128'(busy), 128'(1));
        end
      end
    end
    v = 1'($urandom);
    apply_stimulus(noise ? 1'($urandom) : 1'b0, v, random_data(), sh);
    exp_ds = (exp_ds + 1) % 1024;
    check_output("done_pulse", 128'(done), 128'(1));
    check_output("done_busy", 128'(busy), 128'(0));
    check_output("done_swe", 128'(sram_write_enable), 128'(v));
    check_output("done_index", 128'(matrix_index), 128'(14));
    check_output("done_data", quantized_data, exp_q);
    check_output("done_data_set", 128'(data_set), 128'(exp_ds));
    apply_stimulus(1'b0, 1'b0, random_data(), sh);
    check_output("post_done", 128'(done), 128'(0));
    check_output("post_swe", 128'(sram_write_enable), 128'(0));
    check_output("post_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    logic [255:0] d;
    srstn     = 1'b0;
    start     = 1'b0;
    acc_valid = 1'b0;
    acc_data  = '0;
    shift     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_swe", 128'(sram_write_enable), 128'(0));
    check_output("rst_busy", 128'(busy), 128'(0));
    check_output("rst_done", 128'(done), 128'(0));
    check_output("rst_data_set", 128'(data_set), 128'(0));
    check_output("rst_index", 128'(matrix_index), 128'(0));
    check_output("rst_data", quantized_data, 128'(0));
    srstn = 1'b1;

    apply_stimulus(1'b0, 1'b1, random_data(), 5'd0);
    check_output("idle_swe", 128'(sram_write_enable), 128'(0));
    check_output("idle_busy", 128'(busy), 128'(0));

    $display("[TB] full drain, shift 0, echo pattern");
    run_drain(0, 5'd0, -1, 1'b0, '0);

    $display("[TB] stall after beat 4");
    run_drain(1, 5'd7, 4, 1'b0, '0);

    $display("[TB] saturation");
    d = random_data();
    d[31:0]  = 32'h0100_0000;
    d[63:32] = 32'hFF00_0000;
    d[95:64] = 32'd32767;
    run_drain(2, 5'd0, -1, 1'b0, d);
    check_output("sat_pos", 128'(saved_beat0[15:0]), 128'(16'h7FFF));
    check_output("sat_neg", 128'(saved_beat0[31:16]), 128'(16'h8000));
    check_output("sat_pass", 128'(saved_beat0[47:32]), 128'(16'h7FFF));

    $display("[TB] rounding, shift 8");
    d = random_data();
    d[31:0]  = 32'd4736;
    d[63:32] = -32'sd384;
`ifdef QUANT_ROUND_EN
    run_drain(2, 5'd8, -1, 1'b0, d);
    check_output("round_pos", 128'(saved_beat0[15:0]), 128'(16'd19));
    check_output("round_neg", 128'(saved_beat0[31:16]), 128'(16'hFFFF));
`else
    run_drain(2, 5'd8, -1, 1'b0, d);
    check_output("floor_pos", 128'(saved_beat0[15:0]), 128'(16'd18));
    check_output("floor_neg", 128'(saved_beat0[31:16]), 128'(16'hFFFE));
`endif

    $display("[TB] start and shift noise during drain");
    run_drain(1, 5'd3, 9, 1'b1, '0);
    run_drain(1, 5'd31, 0, 1'b1, '0);

    $display("[TB] asynchronous reset at beat 5");
    apply_stimulus(1'b1, 1'b0, random_data(), 5'd3);
    for (int b = 0; b < 5; b++) apply_stimulus(1'b0, 1'b1, pattern_data(b), 5'd3);
    check_output("pre_rst_busy", 128'(busy), 128'(1));
    acc_valid = 1'b1;
    acc_data  = pattern_data(5);
    #3;
    srstn = 1'b0;
    #1;
    check_output("arst_swe", 128'(sram_write_enable), 128'(0));
    check_output("arst_busy", 128'(busy), 128'(0));
    check_output("arst_index", 128'(matrix_index), 128'(0));
    check_output("arst_data", quantized_data, 128'(0));
    check_output("arst_data_set", 128'(data_set), 128'(0));
    check_output("arst_done", 128'(done), 128'(0));
    @(posedge clk);
    #1;
    srstn  = 1'b1;
    exp_ds = 0;
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b0, 1'b1, random_data(), 5'd0);
      check_output("after_rst_swe", 128'(sram_write_enable), 128'(0));
      check_output("after_rst_busy", 128'(busy), 128'(0));
    end

    $display("[TB] 1024 drains for data_set wrap");
    for (int n = 0; n < 1024; n++) run_drain(1, 5'($urandom), -1, 1'b1, '0);
    check_output("wrap_data_set", 128'(data_set), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quantize_drain.md
Name: quantize_drain

Overview:
- Upstream neighbour of the SRAM write-out stage.
- Drains one skewed result matrix from the systolic array, one anti-diagonal beat per valid cycle, over 2*ARRAY_SIZE-1 beats.
- Each beat: every accumulator lane is arithmetically right-shifted and saturated to OUTPUT_DATA_WIDTH.
- Result is presented with sram_write_enable, matrix_index and data_set, ready for the write-out stage.

Parameters:
ARRAY_SIZE, 8, number of lanes / PE rows
ACC_WIDTH, 32, signed accumulator width per lane
OUTPUT_DATA_WIDTH, 16, signed quantized width per lane

Ports:
clk  input  1  clock, rising edge
srstn  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse: begin draining a matrix
acc_valid  input  1  acc_data holds a valid diagonal beat this cycle
acc_data  input  ARRAY_SIZE*ACC_WIDTH  signed lanes, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
shift  input  5  right-shift amount, 0..31, sampled at start
quantized_data  output  ARRAY_SIZE*OUTPUT_DATA_WIDTH  signed lanes, lane i at [i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]
sram_write_enable  output  1  quantized_data/matrix_index valid this cycle
matrix_index  output  6  beat number 0..2*ARRAY_SIZE-2
data_set  output  10  count of completed matrices
busy  output  1  high in DRAIN and DONE
done  output  1  one-cycle pulse after last beat

Behaviour:
- Reset (asynchronous, srstn=0): state IDLE; all outputs 0; internal beat counter 0; latched shift 0.
- All outputs are registered.
- FSM states: IDLE, DRAIN, DONE.
- IDLE: start=1 latches shift, clears the beat counter and moves to DRAIN next cycle. acc_valid is ignored in IDLE.
- DRAIN, acc_valid=1:
  - Next cycle: quantized_data = quant(acc_data), sram_write_enable=1, matrix_index = beat counter.
  - Beat counter increments.
  - Latency from acc_valid to output is exactly 1 cycle.
- DRAIN, acc_valid=0: next cycle sram_write_enable=0. quantized_data and matrix_index hold their last values. Beat counter holds.
- DRAIN exits to DONE when a valid beat is accepted with beat counter = 2*ARRAY_SIZE-2 (14 at default).
- DONE: lasts one cycle, entered in the same cycle the last beat is presented.
  - Registered outputs in that cycle: done=1, data_set incremented by 1 (wraps 1023->0).
  - sram_write_enable follows acc_valid of the previous cycle, which is ignored for data.
  - Next state is IDLE.
- start is ignored outside IDLE. A start arriving in the DONE cycle is lost; the controller waits for done to fall.
- quant(x), computed per lane independently:
  - Arithmetic shift right by the latched shift, computed in ACC_WIDTH+1 bits.
  - Saturate to [-2^(OUTPUT_DATA_WIDTH-1), 2^(OUTPUT_DATA_WIDTH-1)-1].
- All lanes are quantized every beat. Inactive-diagonal lanes are masked downstream, not here.
- Reset mid-DRAIN: asynchronous abort to IDLE with all outputs 0. data_set also clears.

Optional Feature:
- Macro: QUANT_ROUND_EN.
- Defined: round-half-up. When shift>0, add 2^(shift-1) before shifting, in ACC_WIDTH+1 bits so the add cannot overflow. shift=0 is unchanged.
- Undefined: plain arithmetic shift (floor), no adder in the datapath.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, DRAIN=1, DONE=2)
  - localparam LAST_BEAT = 2*ARRAY_SIZE-2
  - saturation bounds derived from OUTPUT_DATA_WIDTH
- One sub-module, quant_lane: combinational shift/round/saturate for one lane, instantiated ARRAY_SIZE times via generate.
- FSM, counters and output registers stay in quantize_drain.

Test Plan:
- Reset/idle: drive srstn=0 mid-DRAIN (beat 5) -> all outputs 0 immediately, state IDLE; acc_valid pulses afterwards -> no sram_write_enable.
- Full drain: start, then 15 consecutive valid beats with shift=0 and lane i = beat*8+i -> 15 write cycles, matrix_index 0..14, lane values echoed; done pulse in the cycle after index 14; data_set 0->1.
- Stall: deassert acc_valid for 3 cycles after beat 4 -> sram_write_enable low for 3 cycles; matrix_index holds 4 and resumes at 5; still exactly 15 writes.
- Saturation: shift=0 with lane0=0x01000000 and lane1=-0x01000000 -> 32767 and -32768. lane2=32767 passes unchanged.
- Rounding: shift=8 with lane0=4736 and lane1=-384.
  - With QUANT_ROUND_EN: 19 and -1.
  - Without: 18 and -2.
- Wrap/ignore: start asserted during DRAIN -> no effect. Run 1024 drains -> data_set wraps to 0.
